// File: rtl/single_pe_conv.sv
// Single-MAC processing element: 3x3 valid correlation of a 4x4 tile, one MAC per clock.
// Inputs are snapshotted at LOAD; outputs c11, c12, c21, c22 are produced in that order over 36 cycles.
module single_pe_conv #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in11,
  input  logic [DW-1:0] in12,
  input  logic [DW-1:0] in13,
  input  logic [DW-1:0] in14,
  input  logic [DW-1:0] in21,
  input  logic [DW-1:0] in22,
  input  logic [DW-1:0] in23,
  input  logic [DW-1:0] in24,
  input  logic [DW-1:0] in31,
  input  logic [DW-1:0] in32,
  input  logic [DW-1:0] in33,
  input  logic [DW-1:0] in34,
  input  logic [DW-1:0] in41,
  input  logic [DW-1:0] in42,
  input  logic [DW-1:0] in43,
  input  logic [DW-1:0] in44,
  input  logic [DW-1:0] fil11,
  input  logic [DW-1:0] fil12,
  input  logic [DW-1:0] fil13,
  input  logic [DW-1:0] fil21,
  input  logic [DW-1:0] fil22,
  input  logic [DW-1:0] fil23,
  input  logic [DW-1:0] fil31,
  input  logic [DW-1:0] fil32,
  input  logic [DW-1:0] fil33,
  output logic [DW-1:0] c11,
  output logic [DW-1:0] c12,
  output logic [DW-1:0] c21,
  output logic [DW-1:0] c22
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] pix_q [16];
  logic [DW-1:0] tap_q [9];
  logic [DW-1:0] c_q   [4];
  logic [1:0]    tr_q;
  logic [1:0]    tc_q;
  logic [1:0]    oc_q;
  logic [AW-1:0] acc_q;

  logic [1:0]      row_s;
  logic [1:0]      col_s;
  logic [3:0]      pix_idx_s;
  logic [3:0]      tap_idx_s;
  logic [2*DW-1:0] prod_s;
  logic [AW-1:0]   sum_d;
  logic            last_tap_s;

  // Window address: output row/col offset (oc_q[1], oc_q[0]) plus the current tap row/col.
  always_comb begin
    row_s      = {1'b0, oc_q[1]} + tr_q;
    col_s      = {1'b0, oc_q[0]} + tc_q;
    pix_idx_s  = {row_s, col_s};
    tap_idx_s  = ({2'b00, tr_q} * 4'd3) + {2'b00, tc_q};
    prod_s     = pix_q[pix_idx_s] * tap_q[tap_idx_s];
    sum_d      = acc_q + {{(AW-2*DW){1'b0}}, prod_s};
    last_tap_s = (tr_q == 2'd2) && (tc_q == 2'd2);
  end

  // Control FSM, snapshot registers, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LOAD;
      acc_q   <= {AW{1'b0}};
      tr_q    <= 2'd0;
      tc_q    <= 2'd0;
      oc_q    <= 2'd0;
      for (int k = 0; k < 16; k++) pix_q[k] <= {DW{1'b0}};
      for (int k = 0; k < 9; k++)  tap_q[k] <= {DW{1'b0}};
      for (int k = 0; k < 4; k++)  c_q[k]   <= {DW{1'b0}};
    end else begin
      case (state_q)
        LOAD: begin
          pix_q[0]  <= in11;  pix_q[1]  <= in12;  pix_q[2]  <= in13;  pix_q[3]  <= in14;
          pix_q[4]  <= in21;  pix_q[5]  <= in22;  pix_q[6]  <= in23;  pix_q[7]  <= in24;
          pix_q[8]  <= in31;  pix_q[9]  <= in32;  pix_q[10] <= in33;  pix_q[11] <= in34;
          pix_q[12] <= in41;  pix_q[13] <= in42;  pix_q[14] <= in43;  pix_q[15] <= in44;
          tap_q[0]  <= fil11; tap_q[1]  <= fil12; tap_q[2]  <= fil13;
          tap_q[3]  <= fil21; tap_q[4]  <= fil22; tap_q[5]  <= fil23;
          tap_q[6]  <= fil31; tap_q[7]  <= fil32; tap_q[8]  <= fil33;
          acc_q   <= {AW{1'b0}};
          tr_q    <= 2'd0;
          tc_q    <= 2'd0;
          oc_q    <= 2'd0;
          state_q <= COMPUTE;
        end
        COMPUTE: begin
          if (last_tap_s) begin
            c_q[oc_q] <= sum_d[DW-1:0];
            acc_q     <= {AW{1'b0}};
            tr_q      <= 2'd0;
            tc_q      <= 2'd0;
            if (oc_q == 2'd3) begin
              state_q <= DONE;
            end else begin
              oc_q <= oc_q + 2'd1;
            end
          end else begin
            acc_q <= sum_d;
            if (tc_q == 2'd2) begin
              tc_q <= 2'd0;
              tr_q <= tr_q + 2'd1;
            end else begin
              tc_q <= tc_q + 2'd1;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign c11 = c_q[0];
  assign c12 = c_q[1];
  assign c21 = c_q[2];
  assign c22 = c_q[3];

endmodule

// File: tb/tb_single_pe_conv.sv
// Directed bench for single_pe_conv: expected outputs are pushed to a scoreboard at each LOAD
// and popped at the edge where each output becomes valid; all four outputs are checked every edge.
module tb_single_pe_conv;

  logic       clk;
  logic       rst;
  logic [7:0] tin  [16];
  logic [7:0] tfil [9];
  logic [7:0] c11, c12, c21, c22;

  typedef struct {
    int         edge_n;
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] exp_c [4];
  logic [7:0] obs_c [4];
  int         ecnt;
  int         n_cmp;
  int         n_err;

  single_pe_conv #(.DW(8), .AW(20)) dut (
    .clk(clk), .rst(rst),
    .in11(tin[0]),  .in12(tin[1]),  .in13(tin[2]),  .in14(tin[3]),
    .in21(tin[4]),  .in22(tin[5]),  .in23(tin[6]),  .in24(tin[7]),
    .in31(tin[8]),  .in32(tin[9]),  .in33(tin[10]), .in34(tin[11]),
    .in41(tin[12]), .in42(tin[13]), .in43(tin[14]), .in44(tin[15]),
    .fil11(tfil[0]), .fil12(tfil[1]), .fil13(tfil[2]),
    .fil21(tfil[3]), .fil22(tfil[4]), .fil23(tfil[5]),
    .fil31(tfil[6]), .fil32(tfil[7]), .fil33(tfil[8]),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Direct definition: cij = sum fil(r,c) * in(i+r-1, j+c-1), truncated to 8 bits.
  function automatic logic [7:0] model(input int i, input int j);
    int s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'(tfil[r*3+c]) * int'(tin[(i+r)*4 + (j+c)]);
    return 8'(s);
  endfunction

  task automatic step_check(input string tag);
    @(posedge clk);
    #1;
    ecnt++;
    while (sb_q.size() > 0 && sb_q[0].edge_n == ecnt) begin
      exp_c[sb_q[0].idx] = sb_q[0].val;
      void'(sb_q.pop_front());
    end
    obs_c[0] = c11; obs_c[1] = c12; obs_c[2] = c21; obs_c[3] = c22;
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_e%0d_c%0d", tag, ecnt, k), obs_c[k], exp_c[k]);
  endtask

  task automatic run_edges(input string tag, input int n);
    for (int k = 0; k < n; k++) step_check(tag);
  endtask

  // Reset for one edge, expect all outputs cleared, then release and queue the pass results.
  task automatic reset_and_start(input string tag);
    rst = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 4; k++) exp_c[k] = 8'd0;
    ecnt = 0;
    step_check({tag, "_rst"});
    ecnt = 0;
    rst = 1'b1;
    sb_q.push_back('{edge_n: 10, idx: 0, val: model(0, 0)});
    sb_q.push_back('{edge_n: 19, idx: 1, val: model(0, 1)});
    sb_q.push_back('{edge_n: 28, idx: 2, val: model(1, 0)});
    sb_q.push_back('{edge_n: 37, idx: 3, val: model(1, 1)});
  endtask

  task automatic chk_final(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, "_c11"}, c11, e0);
    chk({tag, "_c12"}, c12, e1);
    chk({tag, "_c21"}, c21, e2);
    chk({tag, "_c22"}, c22, e3);
    chk_int({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ecnt  = 0;
    rst   = 1'b0;
    for (int k = 0; k < 16; k++) tin[k] = 8'(k + 1);
    for (int k = 0; k < 9; k++)  tfil[k] = 8'd1;
    for (int k = 0; k < 4; k++)  exp_c[k] = 8'd0;

    // Ones filter on 1..16
    reset_and_start("ones");
    run_edges("ones", 37);
    chk_final("ones", 8'd54, 8'd63, 8'd90, 8'd99);

    // Centre tap only
    for (int k = 0; k < 9; k++) tfil[k] = 8'd0;
    tfil[4] = 8'd1;
    reset_and_start("centre");
    run_edges("centre", 37);
    chk_final("centre", 8'd6, 8'd7, 8'd10, 8'd11);

    // All 255: 585225 mod 256 = 9
    for (int k = 0; k < 16; k++) tin[k] = 8'd255;
    for (int k = 0; k < 9; k++)  tfil[k] = 8'd255;
    reset_and_start("max");
    run_edges("max", 37);
    chk_final("max", 8'd9, 8'd9, 8'd9, 8'd9);

    // Input change after LOAD is ignored
    for (int k = 0; k < 16; k++) tin[k] = 8'(k + 1);
    for (int k = 0; k < 9; k++)  tfil[k] = 8'd1;
    reset_and_start("late");
    run_edges("late", 4);
    tin[0] = 8'd100;
    run_edges("late", 33);
    chk_final("late", 8'd54, 8'd63, 8'd90, 8'd99);

    // Reset at edge 20 after c11/c12 written, restart with taps = 2
    tin[0] = 8'd1;
    reset_and_start("mid");
    run_edges("mid", 19);
    chk("mid_pre_c11", c11, 8'd54);
    chk("mid_pre_c12", c12, 8'd63);
    for (int k = 0; k < 9; k++) tfil[k] = 8'd2;
    reset_and_start("restart");
    run_edges("restart", 37);
    chk_final("restart", 8'd108, 8'd126, 8'd180, 8'd198);

    // Hold: no restart, values stable
    run_edges("hold", 100);
    chk_final("hold", 8'd108, 8'd126, 8'd180, 8'd198);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
